adding_accum: RTL and testbench
===============================

# adding_accum

Parametrised successor to the team's combinational two-operand adder. Registered add/accumulate engine: accepts two W-bit operands per valid/ready transfer and returns either their plain sum or a running accumulator total, with selectable saturate-or-wrap overflow and a sticky overflow flag. Sits between operand producers and any downstream consumer needing backpressure-safe, one-cycle-latency arithmetic.

## Interface
- W, default 5, operand width in bits (>= 1)
- OUT_W, default 8, result/accumulator width (>= W+1)
- SAT, default 1, 1 = accumulator saturates at 2^OUT_W-1, 0 = wraps modulo 2^OUT_W
- clk  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-low (0 = reset, sampled on clk rising edge)
- in_valid  in  1  operands and mode valid
- in_ready  out  1  block can accept this cycle
- in1  in  W  operand 1, unsigned
- in2  in  W  operand 2, unsigned
- mode  in  2  0 ADD, 1 ACC, 2 LOAD, 3 CLEAR
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out  out  OUT_W  result, unsigned
- ovf  out  1  sticky overflow flag

## Operation
- Accept = in_valid && in_ready; in_ready = !out_valid || out_ready (combinational through out_ready only).
- s = in1 + in2, zero-extended to OUT_W+1 bits; never overflows OUT_W.
- ADD: out <= s; acc unchanged; ovf unchanged.
- ACC: t = acc + s (OUT_W+1 bits). If t > 2^OUT_W-1: ovf <= 1, acc/out <= all-ones (SAT=1) or t mod 2^OUT_W (SAT=0). Else acc/out <= t.
- LOAD: acc <= s; out <= s; ovf unchanged.
- CLEAR: acc <= 0; out <= 0; ovf <= 0; operands ignored.
- ovf is cleared only by CLEAR or reset; it is never cleared by ADD, ACC or LOAD.
- No accept: acc, ovf, out unchanged. out_valid cleared when out_valid && out_ready && !accept.
- Out-of-range parameters (OUT_W < W+1) are a compile-time error.

## Timing
- Reset (reset = 0 at a rising edge): out_valid = 0, out = 0, acc = 0, ovf = 0. A pending result is dropped. in_ready reads 1 from the first cycle after reset.
- Latency: result and updated ovf appear on out/ovf the cycle after accept, with out_valid = 1.
- Stall: while out_valid && !out_ready, out, out_valid, ovf and acc hold. in_ready = 0, so input changes are ignored.
- Simultaneous drain and accept (out_valid && out_ready && in_valid): the old result transfers this edge, the new result loads the same edge, and out_valid stays 1. Full throughput is one op per cycle.
- ACC chains are back-to-back: each accept sees acc as updated by the previous accept, with no bubble.
- Reset asserted in the same cycle as an accept: reset wins and the operation is discarded.

## Structure
- Package adding_pkg:
  - typedef enum logic [1:0] add_mode_e {ADD, ACC, LOAD, CLEAR}
  - localparam default widths
- One sub-module, adding_sat: combinational, parameters OUT_W and SAT.
  - Inputs: a[OUT_W], b[OUT_W+1].
  - Outputs: sum[OUT_W], of.
  - Used for the ACC path.
- Top holds the output register, acc, ovf, out_valid and handshake logic.

## Test plan
All scenarios use W=5, OUT_W=8, with out_ready=1 unless stated.
- Reset then ADD 31+31 -> next cycle out=62, out_valid=1, ovf=0; acc stays 0, so a following ACC 0+0 gives out=0.
- LOAD 10+5, then ACC 20+0, then ACC 1+1 back-to-back -> outs 15, 35, 37 on consecutive cycles, out_valid held high.
- SAT=1 overflow: LOAD 31+31, then four ACC 31+31 -> outs 62, 124, 186, 248, 255. ovf rises with the 255 result; a further ACC 1+0 gives 255 with ovf=1.
- SAT=0 overflow: same stimulus -> outs 62, 124, 186, 248, 54 with ovf=1. Then ADD 2+3 -> out=5 with ovf still 1. Then CLEAR -> out=0, ovf=0.
- Backpressure:
  - ADD 3+4 accepted, then out_ready=0 for 3 cycles while in1/in2 toggle with in_valid=1 -> out holds 7, in_ready=0.
  - out_ready=1 -> 7 transfers, and the pending input is accepted the same edge.
- Reset mid-stall: hold out_valid=1 with acc=100, then drive reset=0 for one cycle -> out_valid=0, out=0, ovf=0. Then ACC 1+1 -> out=2.

Source files
------------

// File: rtl/adding_pkg.sv
// adding_pkg: shared types and default widths for the adding_accum engine.
// Holds the operation-mode enum and default parameter values.
package adding_pkg;

    typedef enum logic [1:0] {
        ADD   = 2'd0,
        ACC   = 2'd1,
        LOAD  = 2'd2,
        CLEAR = 2'd3
    } add_mode_e;

    localparam int W_DEF     = 5;
    localparam int OUT_W_DEF = 8;
    localparam bit SAT_DEF   = 1'b1;

endpackage

// File: rtl/adding_sat.sv
// adding_sat: combinational accumulator adder with saturate-or-wrap result.
// Ports: a (acc, OUT_W), b (addend, OUT_W+1) -> sum (OUT_W), of (overflow).
module adding_sat #(
    parameter int OUT_W = 8,
    parameter bit SAT   = 1'b1
) (
    input  logic [OUT_W-1:0] a,
    input  logic [OUT_W:0]   b,
    output logic [OUT_W-1:0] sum,
    output logic             of
);

    logic [OUT_W+1:0] t;

    always_comb begin
        t   = {2'b00, a} + {1'b0, b};
        // Anything at or above 2^OUT_W no longer fits the accumulator.
        of  = (t[OUT_W+1:OUT_W] != 2'b00);
        sum = t[OUT_W-1:0];
        if (of && SAT) begin
            sum = '1;
        end
    end

endmodule

// File: rtl/adding_accum.sv
// adding_accum: registered add/accumulate engine, one-cycle latency, valid/ready.
// Ports: clk, reset (sync, active-low), in_valid/in_ready/in1/in2/mode, out_valid/out_ready/out, ovf.
module adding_accum
    import adding_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int OUT_W = OUT_W_DEF,
    parameter bit SAT   = SAT_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in1,
    input  logic [W-1:0]     in2,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out,
    output logic             ovf
);

    generate
        if (OUT_W < W + 1) begin : g_bad_width
            $error("adding_accum: OUT_W must be at least W+1");
        end
    endgenerate

    logic             accept;
    add_mode_e        op;
    logic [OUT_W:0]   s;
    logic [OUT_W-1:0] acc;
    logic [OUT_W-1:0] acc_sum;
    logic             acc_of;

    // Ready depends combinationally on out_ready only, so a full
    // pipeline can drain and refill on the same edge.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign op       = add_mode_e'(mode);

    // Operand sum cannot exceed OUT_W bits since OUT_W >= W+1.
    assign s = (OUT_W+1)'(in1) + (OUT_W+1)'(in2);

    adding_sat #(
        .OUT_W (OUT_W),
        .SAT   (SAT)
    ) u_sat (
        .a   (acc),
        .b   (s),
        .sum (acc_sum),
        .of  (acc_of)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out       <= '0;
            acc       <= '0;
            ovf       <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            unique case (op)
                ADD: begin
                    out <= s[OUT_W-1:0];
                end
                ACC: begin
                    acc <= acc_sum;
                    out <= acc_sum;
                    if (acc_of) begin
                        ovf <= 1'b1;
                    end
                end
                LOAD: begin
                    acc <= s[OUT_W-1:0];
                    out <= s[OUT_W-1:0];
                end
                CLEAR: begin
                    acc <= '0;
                    out <= '0;
                    ovf <= 1'b0;
                end
            endcase
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_adding_accum.sv
// tb_adding_accum: vector table, corner sequences and random run against a model.
// Two instances (SAT=1 and SAT=0) share the same stimulus.
module tb_adding_accum;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic [4:0] in1;
    logic [4:0] in2;
    logic [1:0] mode;
    logic       out_ready;

    logic       in_ready1, in_ready0;
    logic       out_valid1, out_valid0;
    logic [7:0] out1, out0;
    logic       ovf1, ovf0;

    int n_cmp = 0;
    int n_bad = 0;

    adding_accum #(.W(5), .OUT_W(8), .SAT(1'b1)) dut1 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready1),
        .in1       (in1),
        .in2       (in2),
        .mode      (mode),
        .out_valid (out_valid1),
        .out_ready (out_ready),
        .out       (out1),
        .ovf       (ovf1)
    );

    adding_accum #(.W(5), .OUT_W(8), .SAT(1'b0)) dut0 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready0),
        .in1       (in1),
        .in2       (in2),
        .mode      (mode),
        .out_valid (out_valid0),
        .out_ready (out_ready),
        .out       (out0),
        .ovf       (ovf0)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    // Reference model, index 0 = wrapping, index 1 = saturating.
    int m_acc [2];
    int m_out [2];
    bit m_vld [2];
    bit m_ovf [2];
    bit init = 1'b0;
    bit rdy_seen;

    task automatic cmp(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic step(input bit v, input int a, input int b,
                        input int m, input bit ordy, input bit rst);
        bit go;
        int sum;
        int t;
        in_valid  = v;
        in1       = 5'(a);
        in2       = 5'(b);
        mode      = 2'(m);
        out_ready = ordy;
        reset     = rst;
        #1;
        rdy_seen = in_ready1;
        if (init) begin
            cmp("rdy1", int'(in_ready1), int'(!m_vld[1] || ordy));
            cmp("rdy0", int'(in_ready0), int'(!m_vld[0] || ordy));
        end
        @(posedge clk);
        go  = v && (!m_vld[0] || ordy);
        sum = a + b;
        for (int k = 0; k < 2; k++) begin
            if (!rst) begin
                m_acc[k] = 0;
                m_out[k] = 0;
                m_vld[k] = 1'b0;
                m_ovf[k] = 1'b0;
            end else if (go) begin
                m_vld[k] = 1'b1;
                case (m)
                    0: m_out[k] = sum;
                    1: begin
                        t = m_acc[k] + sum;
                        if (t > 255) begin
                            m_ovf[k] = 1'b1;
                            t = (k == 1) ? 255 : t % 256;
                        end
                        m_acc[k] = t;
                        m_out[k] = t;
                    end
                    2: begin
                        m_acc[k] = sum;
                        m_out[k] = sum;
                    end
                    default: begin
                        m_acc[k] = 0;
                        m_out[k] = 0;
                        m_ovf[k] = 1'b0;
                    end
                endcase
            end else if (ordy) begin
                m_vld[k] = 1'b0;
            end
        end
        init = 1'b1;
        #1;
        cmp("vld1", int'(out_valid1), int'(m_vld[1]));
        cmp("vld0", int'(out_valid0), int'(m_vld[0]));
        cmp("out1", int'(out1), m_out[1]);
        cmp("out0", int'(out0), m_out[0]);
        cmp("ovf1", int'(ovf1), int'(m_ovf[1]));
        cmp("ovf0", int'(ovf0), int'(m_ovf[0]));
    endtask

    typedef struct {
        bit v;
        int a;
        int b;
        int m;
        bit ordy;
        bit rst;
        bit ex_rdy;
        bit ex_vld;
        int ex_o1;
        int ex_o0;
        bit ex_f1;
        bit ex_f0;
    } vec_t;

    function automatic vec_t mk(bit v, int a, int b, int m, bit ordy, bit rst,
                                bit er, bit ev, int o1, int o0, bit f1, bit f0);
        vec_t r;
        r.v = v; r.a = a; r.b = b; r.m = m; r.ordy = ordy; r.rst = rst;
        r.ex_rdy = er; r.ex_vld = ev; r.ex_o1 = o1; r.ex_o0 = o0;
        r.ex_f1 = f1; r.ex_f0 = f0;
        return r;
    endfunction

    localparam int MA = 0, MC = 1, ML = 2, MK = 3;

    vec_t tbl [26];

    initial begin
        tbl[0]  = mk(1, 31, 31, MA, 1, 1, 1, 1,  62,  62, 0, 0);
        tbl[1]  = mk(1,  0,  0, MC, 1, 1, 1, 1,   0,   0, 0, 0);
        tbl[2]  = mk(1, 10,  5, ML, 1, 1, 1, 1,  15,  15, 0, 0);
        tbl[3]  = mk(1, 20,  0, MC, 1, 1, 1, 1,  35,  35, 0, 0);
        tbl[4]  = mk(1,  1,  1, MC, 1, 1, 1, 1,  37,  37, 0, 0);
        tbl[5]  = mk(1, 31, 31, ML, 1, 1, 1, 1,  62,  62, 0, 0);
        tbl[6]  = mk(1, 31, 31, MC, 1, 1, 1, 1, 124, 124, 0, 0);
        tbl[7]  = mk(1, 31, 31, MC, 1, 1, 1, 1, 186, 186, 0, 0);
        tbl[8]  = mk(1, 31, 31, MC, 1, 1, 1, 1, 248, 248, 0, 0);
        tbl[9]  = mk(1, 31, 31, MC, 1, 1, 1, 1, 255,  54, 1, 1);
        tbl[10] = mk(1,  1,  0, MC, 1, 1, 1, 1, 255,  55, 1, 1);
        tbl[11] = mk(1,  2,  3, MA, 1, 1, 1, 1,   5,   5, 1, 1);
        tbl[12] = mk(1,  7,  7, MK, 1, 1, 1, 1,   0,   0, 0, 0);
        tbl[13] = mk(0,  0,  0, MA, 1, 1, 1, 0,   0,   0, 0, 0);
        tbl[14] = mk(1,  3,  4, MA, 1, 1, 1, 1,   7,   7, 0, 0);
        tbl[15] = mk(1,  9,  9, MA, 0, 1, 0, 1,   7,   7, 0, 0);
        tbl[16] = mk(1,  1,  2, MA, 0, 1, 0, 1,   7,   7, 0, 0);
        tbl[17] = mk(1, 30,  1, MC, 0, 1, 0, 1,   7,   7, 0, 0);
        tbl[18] = mk(1, 10, 10, MA, 1, 1, 1, 1,  20,  20, 0, 0);
        tbl[19] = mk(1, 25, 25, ML, 1, 1, 1, 1,  50,  50, 0, 0);
        tbl[20] = mk(1, 25, 25, MC, 1, 1, 1, 1, 100, 100, 0, 0);
        tbl[21] = mk(0,  0,  0, MA, 0, 1, 0, 1, 100, 100, 0, 0);
        tbl[22] = mk(1,  5,  5, MC, 0, 0, 0, 0,   0,   0, 0, 0);
        tbl[23] = mk(1,  1,  1, MC, 1, 1, 1, 1,   2,   2, 0, 0);
        tbl[24] = mk(1,  3,  3, MC, 1, 0, 1, 0,   0,   0, 0, 0);
        tbl[25] = mk(1,  1,  1, MC, 1, 1, 1, 1,   2,   2, 0, 0);

        step(0, 0, 0, MA, 1, 0);
        step(0, 0, 0, MA, 1, 0);
        cmp("rst_vld", int'(out_valid1), 0);
        cmp("rst_out", int'(out1), 0);
        cmp("rst_ovf", int'(ovf1), 0);
        cmp("rst_rdy", int'(in_ready1), 1);

        for (int i = 0; i < 26; i++) begin
            step(tbl[i].v, tbl[i].a, tbl[i].b, tbl[i].m, tbl[i].ordy, tbl[i].rst);
            cmp($sformatf("t%0d_rdy", i), int'(rdy_seen), int'(tbl[i].ex_rdy));
            cmp($sformatf("t%0d_vld", i), int'(out_valid1), int'(tbl[i].ex_vld));
            cmp($sformatf("t%0d_o1", i), int'(out1), tbl[i].ex_o1);
            cmp($sformatf("t%0d_o0", i), int'(out0), tbl[i].ex_o0);
            cmp($sformatf("t%0d_f1", i), int'(ovf1), int'(tbl[i].ex_f1));
            cmp($sformatf("t%0d_f0", i), int'(ovf0), int'(tbl[i].ex_f0));
        end

        // Sticky ovf survives LOAD and a stalled idle cycle.
        step(1, 31, 31, ML, 1, 1);
        for (int i = 0; i < 4; i++) step(1, 31, 31, MC, 1, 1);
        step(1, 1, 1, ML, 1, 1);
        cmp("seq_load_o1", int'(out1), 2);
        cmp("seq_load_f1", int'(ovf1), 1);
        cmp("seq_load_f0", int'(ovf0), 1);
        step(0, 0, 0, MA, 0, 1);
        cmp("seq_hold_f1", int'(ovf1), 1);
        cmp("seq_hold_o0", int'(out0), 2);
        step(1, 4, 4, MC, 1, 1);
        cmp("seq_acc_o1", int'(out1), 10);
        cmp("seq_acc_f0", int'(ovf0), 1);

        for (int i = 0; i < 500; i++) begin
            step($urandom_range(0, 3) != 0,
                 $urandom_range(0, 31), $urandom_range(0, 31),
                 ($urandom_range(0, 2) == 0) ? MC : $urandom_range(0, 3),
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 59) != 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
